// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_port peripheral.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_port_if.sv
// CPU-side bus between the control decoder (master) and the UART (slave).
interface uart_port_if;
  import uart_pkg::*;

  logic                      _uart_in;
  logic                      _uart_out;
  logic [UART_DATA_BITS-1:0] data_in;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      _data_oe;
  logic                      _uart_in_ready;
  logic                      _uart_out_ready;

  modport master (
    output _uart_in, _uart_out, data_in,
    input  data_out, _data_oe, _uart_in_ready, _uart_out_ready
  );

  modport slave (
    input  _uart_in, _uart_out, data_in,
    output data_out, _data_oe, _uart_in_ready, _uart_out_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: rx synchroniser, 8N1 deserialiser, single-byte holding register, sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  input  logic                      rd,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      ready_n,
  output logic                      overrun,
  output logic                      frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    B_LAST = 3'(UART_DATA_BITS - 1);

  logic                      sync1, sync2, prev;
  rx_state_t                 state;
  logic [TW-1:0]             timer;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      full;
  logic                      fall, stop_done, load;

  assign fall      = prev & ~sync2;
  assign stop_done = (state == RX_STOP) && (timer == T_LAST);
  assign load      = stop_done & sync2;
  assign ready_n   = ~full;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Frame FSM: mid-start check rejects glitches, then one sample per bit period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RX_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (fall) begin
            timer <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (timer == T_HALF) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == T_LAST) begin
            timer <= '0;
            shreg <= {sync2, shreg[UART_DATA_BITS-1:1]};
            if (bit_idx == B_LAST) state <= RX_STOP;
            else                   bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            state <= RX_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Holding register: a same-edge read frees the slot, so a completing byte is never an overrun then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      full      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (stop_done && !sync2) frame_err <= 1'b1;
      if (load && full && !rd) overrun <= 1'b1;
      if (load && (!full || rd)) begin
        data <= shreg;
        full <= 1'b1;
      end else if (rd && full) begin
        data <= '0;
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_port.sv
// CPU-side 8N1 UART: TX FIFO with serialiser here, receive path in uart_rx.
module uart_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  uart_port_if.slave  bus,
  output logic        tx,
  input  logic        rx,
  output logic        rx_overrun,
  output logic        rx_frame_err
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    B_LAST = 3'(UART_DATA_BITS - 1);

  logic [UART_DATA_BITS-1:0] mem [TX_DEPTH];
  logic [PW:0]               wr_ptr, rd_ptr, wr_next, rd_next;
  logic                      empty, full, push, pop, out_ready_n;
  tx_state_t                 tx_state;
  logic [TW-1:0]             tx_timer;
  logic [2:0]                tx_bit;
  logic [UART_DATA_BITS-1:0] tx_shreg;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push    = ~bus._uart_in & ~full;
  assign pop     = (tx_state == TX_IDLE) & ~empty;
  assign wr_next = wr_ptr + {{PW{1'b0}}, push};
  assign rd_next = rd_ptr + {{PW{1'b0}}, pop};

  assign bus._data_oe        = bus._uart_out;
  assign bus._uart_out_ready = out_ready_n;

  // FIFO storage; writes to a full FIFO are dropped by the push qualifier.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= bus.data_in;
  end

  // FIFO pointers and the registered "no free slot" flag, computed from post-edge occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_ready_n <= 1'b0;
    end else begin
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      out_ready_n <= (wr_next[PW] != rd_next[PW]) && (wr_next[PW-1:0] == rd_next[PW-1:0]);
    end
  end

  // Serialiser FSM; tx is registered from the current state, giving the two-edge write-to-start latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= (tx_state == TX_START) ? 1'b0 :
            (tx_state == TX_DATA)  ? tx_shreg[0] : 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_shreg <= mem[rd_ptr[PW-1:0]];
            tx_timer <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_timer == T_LAST) begin
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_timer == T_LAST) begin
            tx_timer <= '0;
            tx_shreg <= {1'b0, tx_shreg[UART_DATA_BITS-1:1]};
            if (tx_bit == B_LAST) tx_state <= TX_STOP;
            else                  tx_bit   <= tx_bit + 1'b1;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_timer == T_LAST) begin
            tx_timer <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (!bus._uart_out),
    .data      (bus.data_out),
    .ready_n   (bus._uart_in_ready),
    .overrun   (rx_overrun),
    .frame_err (rx_frame_err)
  );

endmodule

// File: tb/tb_uart_port.sv
// Directed + randomized bench for uart_port with a behavioural serial monitor and holding-register model.
module tb_uart_port;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset, tx, rx, rx_overrun, rx_frame_err;

  uart_port_if bus_if ();

  uart_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .tx           (tx),
    .rx           (rx),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic       stop_q[$];
  logic       mon_abort = 1'b0;

  // Reference model of the RX holding register and sticky flags.
  logic       m_full, m_ovr, m_ferr;
  logic [7:0] m_hold;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Serial line decoder: waits on negedges, sampling each bit near its middle.
  task automatic mon_wait(int n);
    repeat (n) begin
      @(negedge clk);
      if (reset) mon_abort = 1'b1;
    end
  endtask

  initial begin : tx_monitor
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        mon_abort = 1'b0;
        mon_wait(CPB / 2);
        if (tx === 1'b0 && !mon_abort) begin
          for (int i = 0; i < 8; i++) begin
            mon_wait(CPB);
            b[i] = tx;
          end
          mon_wait(CPB);
          sb = tx;
          if (!mon_abort) begin
            got_q.push_back(b);
            stop_q.push_back(sb);
          end
        end
      end
    end
  end

  task automatic expect_tx(string tag, logic [7:0] exp);
    int n = 0;
    while (got_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      check({tag, "_timeout"}, got_q.size(), 1);
    end else begin
      check(tag, got_q.pop_front(), exp);
      check({tag, "_stop"}, stop_q.pop_front(), 1);
    end
  endtask

  task automatic do_write(logic [7:0] b);
    @(negedge clk);
    bus_if._uart_in = 1'b0;
    bus_if.data_in  = b;
    @(negedge clk);
    bus_if._uart_in = 1'b1;
  endtask

  task automatic send_rx(logic [7:0] b, logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (!stop_bit)   m_ferr = 1'b1;
    else if (m_full) m_ovr  = 1'b1;
    else begin
      m_full = 1'b1;
      m_hold = b;
    end
  endtask

  task automatic do_read(string tag);
    @(negedge clk);
    bus_if._uart_out = 1'b0;
    #1 check({tag, "_oe_low"}, bus_if._data_oe, 0);
    @(negedge clk);
    bus_if._uart_out = 1'b1;
    #1 check({tag, "_oe_high"}, bus_if._data_oe, 1);
    if (m_full) begin
      m_full = 1'b0;
      m_hold = 8'h00;
    end
  endtask

  task automatic check_rx(string tag);
    check({tag, "_data"},  bus_if.data_out,       m_hold);
    check({tag, "_ready"}, bus_if._uart_in_ready, !m_full);
    check({tag, "_ovr"},   rx_overrun,            m_ovr);
    check({tag, "_ferr"},  rx_frame_err,          m_ferr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_hold = 8'h00;
  endtask

  initial begin : stimulus
    logic [7:0] exp_q[$];
    logic [7:0] r, r2;
    int         pending, n;
    logic       seen_low;

    reset            = 1'b1;
    rx               = 1'b1;
    bus_if._uart_in  = 1'b1;
    bus_if._uart_out = 1'b1;
    bus_if.data_in   = 8'h00;
    m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_hold = 8'h00;

    // Reset state
    #12;
    check("rst_tx",        tx,                      1);
    check("rst_data_out",  bus_if.data_out,         0);
    check("rst_in_ready",  bus_if._uart_in_ready,   1);
    check("rst_out_ready", bus_if._uart_out_ready,  0);
    check("rst_ovr",       rx_overrun,              0);
    check("rst_ferr",      rx_frame_err,            0);
    check("rst_oe",        bus_if._data_oe,         1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte TX with write-to-start latency
    bus_if._uart_in = 1'b0;
    bus_if.data_in  = 8'hA5;
    @(posedge clk); #1 check("lat_edge0", tx, 1);
    @(negedge clk); bus_if._uart_in = 1'b1;
    @(posedge clk); #1 check("lat_edge1", tx, 1);
    @(posedge clk); #1 check("lat_edge2", tx, 0);
    expect_tx("tx_a5", 8'hA5);

    // Random TX bytes
    for (int k = 0; k < 3; k++) begin
      r = 8'($urandom);
      exp_q.push_back(r);
      do_write(r);
    end
    while (exp_q.size() > 0) expect_tx("tx_rand", exp_q.pop_front());

    // FIFO full: one byte in the shifter, then five back-to-back writes into a 4-deep FIFO
    do_write(8'h01);
    exp_q.push_back(8'h01);
    @(negedge clk);
    pending = 0;
    bus_if._uart_in = 1'b0;
    bus_if.data_in  = 8'h02;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (pending < DEPTH) begin
        pending++;
        exp_q.push_back(8'(8'h02 + k));
      end
      check("fifo_ready", bus_if._uart_out_ready, (pending == DEPTH) ? 1 : 0);
      if (k < 4) bus_if.data_in = 8'(8'h03 + k);
      else       bus_if._uart_in = 1'b1;
    end
    n = 0;
    while (bus_if._uart_out_ready === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_pop", bus_if._uart_out_ready, 0);
    while (exp_q.size() > 0) expect_tx("tx_fifo", exp_q.pop_front());
    repeat (60) @(negedge clk);
    check("fifo_dropped", got_q.size(), 0);

    // Single byte RX and read pulse
    send_rx(8'h3C, 1'b1);
    check_rx("rx_3c");
    do_read("rd_3c");
    check_rx("rx_3c_read");

    // Random RX bytes
    for (int k = 0; k < 2; k++) begin
      r = 8'($urandom);
      send_rx(r, 1'b1);
      check_rx("rx_rand");
      do_read("rd_rand");
      check_rx("rx_rand_read");
    end

    // Overrun: second byte lost, first byte kept
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    check_rx("rx_ovr");
    do_read("rd_ovr");

    // Framing error
    send_rx(8'h55, 1'b0);
    check_rx("rx_ferr");

    // One-clock glitch on rx
    do_reset();
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (20) @(negedge clk);
    check_rx("rx_glitch");

    // Reset in the third data bit of a TX frame, with more bytes queued
    @(negedge clk);
    bus_if._uart_in = 1'b0;
    bus_if.data_in  = 8'hF0;
    @(negedge clk); bus_if.data_in = 8'h77;
    @(negedge clk); bus_if.data_in = 8'h88;
    @(negedge clk); bus_if._uart_in = 1'b1;
    repeat (13) @(negedge clk);
    check("mid_bit2_low", tx, 0);
    #2 reset = 1'b1;
    #1 check("reset_tx_now", tx, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_hold = 8'h00;
    #1 check("post_rst_ready", bus_if._uart_out_ready, 0);
    seen_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("post_rst_idle", seen_low, 0);
    check("post_rst_frames", got_q.size(), 0);

    // Simultaneous write and read on one edge
    r  = 8'($urandom);
    r2 = 8'($urandom);
    send_rx(r, 1'b1);
    check_rx("rx_pre_sim");
    @(negedge clk);
    bus_if._uart_in  = 1'b0;
    bus_if.data_in   = r2;
    bus_if._uart_out = 1'b0;
    @(negedge clk);
    bus_if._uart_in  = 1'b1;
    bus_if._uart_out = 1'b1;
    m_full = 1'b0;
    m_hold = 8'h00;
    check_rx("rx_sim");
    expect_tx("tx_sim", r2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
